cache_fill_fsm: RTL
===================

Name: cache_fill_fsm

Overview:
- Miss-handling fill controller that sits directly upstream of the cache data array (128 lines × 8 words × 16 bits) and its tag array.
- On a cache miss, it issues 8 pipelined word reads to main memory and collects the returned words.
- It writes each returned word into the data array using a one-hot block enable and a one-hot word enable.
- On the last word, it writes the tag array. While the fill is in progress, it holds the pipeline through fsm_busy.

Parameters:
- ADDR_W, 16, byte-address width
- WORDS, 8, words per cache line; word index = addr[3:1]
- LINES, 128, lines in the data array; line index = addr[10:4]; tag = addr[15:11]

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- miss_detected  in  1  cache miss this cycle; sampled only in IDLE
- miss_address  in  16  byte address of the missing access
- memory_data  in  16  word returned by memory
- memory_data_valid  in  1  memory_data is valid this cycle
- fsm_busy  out  1  fill in progress; the pipeline stalls while this is high
- mem_read  out  1  read request to memory this cycle
- memory_address  out  16  byte address of the current read request
- write_data_array  out  1  write strobe to the data array
- write_tag_array  out  1  write strobe to the tag array
- block_enable  out  128  one-hot line select
- word_enable  out  8  one-hot word select
- data_out  out  16  data to the data array (equal to memory_data)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset state: state=IDLE, issue_cnt=0, ret_cnt=0, base=0. Every output is 0, except data_out, which follows memory_data.
- Memory model: fixed 4-cycle latency. Memory accepts one read per cycle, fully pipelined, and returns data in request order.
- States:
  - IDLE: if miss_detected, latch base={miss_address[15:4],4'b0000}, clear both counters, and go to FILL next edge.
  - FILL, issue side: while issue_cnt<8, drive mem_read=1 and memory_address=base+{issue_cnt,1'b0}, then increment issue_cnt. mem_read=0 once issue_cnt=8.
  - FILL, return side: when memory_data_valid=1, drive combinationally in the same cycle:
    - write_data_array=1
    - word_enable=onehot(ret_cnt)
    - block_enable=onehot(base[10:4])
    - ret_cnt increments.
  - FILL, last word: when ret_cnt=7 and memory_data_valid=1, also drive write_tag_array=1 in that cycle, then go to IDLE next edge.
- fsm_busy: registered. It is 1 from the cycle after miss_detected through the cycle of the final data write, and 0 in the next cycle.
- Fill latency: first request in cycle N+1 after a miss in cycle N. Last write in cycle N+12. Total busy 12 cycles.
- Enables outside writes: block_enable and word_enable are all-zero whenever write_data_array=0.
- Ignored inputs:
  - memory_data_valid in IDLE
  - miss_detected in FILL, including a miss in the same cycle as the final write; the new miss is honoured in the next IDLE cycle only if still asserted.
- Counters: 4-bit, saturating at 8, never wrap. base addition stays within the line, so there is no carry out of bit 3.
- Reset mid-fill: abort immediately to IDLE. No further strobes are issued. Partially written words stay in the data array, and the tag is not written, so the line stays invalid.
- One-hot guarantees: word_enable and block_enable have at most one bit set in any cycle.

Decomposition:
- Shared package cache_pkg:
  - constants WORDS, LINES, OFFSET_W=4, INDEX_W=7, TAG_W=5
  - state encoding IDLE=1'b0, FILL=1'b1
- Sub-module onehot_decoder (parameter N, input index [$clog2(N)-1:0] plus en, output [N-1:0]). It is instantiated twice: 8-way for word_enable and 128-way for block_enable.

Test Plan:
1. Reset then idle: hold rst 2 cycles, toggle memory_data_valid -> all strobes 0, fsm_busy=0.
2. Basic fill:
   - Stimulus: miss_address=16'h1A36 at cycle 0; memory returns 16'h1000..16'h1007.
   - Requests: mem_read cycles 1-8 at addresses 16'h1A30,16'h1A32,...,16'h1A3E.
   - Writes: cycles 5-12 with word_enable 8'h01..8'h80, block_enable bit 16'h1A3>>0 & 7'h7F = index 7'h23.
   - Tag and busy: write_tag_array only at cycle 12; fsm_busy high for cycles 1-12.
3. Miss during fill: pulse miss_detected=1 with 16'h0040 at cycle 6 of an active fill -> ignored. base is unchanged, and there is no second fill.
4. Back-to-back misses: miss_detected held high through the end of a fill with 16'h0070 -> second fill starts at base 16'h0070 in the cycle after fsm_busy falls. No overlap of strobes.
5. Reset mid-fill: assert rst at cycle 7 -> next cycle in IDLE, fsm_busy=0, no further write_data_array, write_tag_array never asserted.
6. Line boundaries: miss_address=16'hFFFE -> addresses 16'hFFF0..16'hFFFE, block_enable bit 127, no address wrap past 16'hFFFE.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache line-fill controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_pkg;

    localparam int ADDR_W   = 16;                 // byte-address width
    localparam int WORDS    = 8;                  // 16-bit words per line
    localparam int LINES    = 128;                // lines in the data array
    localparam int OFFSET_W = 4;                  // byte offset bits within a line
    localparam int INDEX_W  = 7;                  // line index bits, addr[10:4]
    localparam int TAG_W    = 5;                  // tag bits, addr[15:11]
    localparam int WIDX_W   = OFFSET_W - 1;       // word index bits, addr[3:1]
    localparam int CNT_W    = 4;                  // fill counters, saturate at WORDS
    localparam int LBASE_W  = ADDR_W - OFFSET_W;  // line-aligned base, addr[15:4]

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bundle of the miss, memory and array-write signals around the fill controller.
// Latency: n/a (wiring only).
// Backpressure: none; memory is a fixed-latency pipe and the pipeline stalls on fsm_busy.
// Ports: master = fill controller side, slave = pipeline/memory/array side.
interface cache_fill_fsm_if;
    import cache_pkg::*;

    logic                miss_detected;
    logic [ADDR_W-1:0]   miss_address;
    logic [15:0]         memory_data;
    logic                memory_data_valid;
    logic                fsm_busy;
    logic                mem_read;
    logic [ADDR_W-1:0]   memory_address;
    logic                write_data_array;
    logic                write_tag_array;
    logic [LINES-1:0]    block_enable;
    logic [WORDS-1:0]    word_enable;
    logic [15:0]         data_out;

    modport master (
        input  miss_detected, miss_address, memory_data, memory_data_valid,
        output fsm_busy, mem_read, memory_address, write_data_array,
               write_tag_array, block_enable, word_enable, data_out
    );

    modport slave (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  fsm_busy, mem_read, memory_address, write_data_array,
               write_tag_array, block_enable, word_enable, data_out
    );

endinterface

// File: rtl/onehot_decoder.sv
// Binary index to one-hot select, forced all-zero when not enabled.
// Latency: combinational.
// Backpressure: none.
// Ports: index_i (binary select), en_i (enable), onehot_o (N-bit one-hot or zero).
module onehot_decoder #(
    parameter int N = 8
) (
    input  logic [$clog2(N)-1:0] index_i,
    input  logic                 en_i,
    output logic [N-1:0]         onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[index_i] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Line-fill controller: on a miss, streams 8 word reads to memory and writes the returns into the data/tag arrays.
// Latency: first read 1 cycle after the miss; with 4-cycle memory the tag write lands 12 cycles after the miss.
// Backpressure: none accepted; holds the pipeline with fsm_busy for the whole fill and ignores new misses meanwhile.
// Ports: clk, rst (sync, active-high), bus (cache_fill_fsm_if.master: miss in, memory req/resp, array write strobes).
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    cache_fill_fsm_if.master  bus
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;
    logic [LBASE_W-1:0]  line_base_q, line_base_d;  // addr[15:4] of the line being filled
    logic                word_wr;                   // a returned word is written this cycle
    logic                mem_read;
    logic [ADDR_W-1:0]   memory_address;
    logic                tag_wr;

    // Byte offset of the miss is irrelevant: the whole line is fetched.
    logic [OFFSET_W-1:0] unused_miss_offset;
    assign unused_miss_offset = bus.miss_address[OFFSET_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            line_base_q <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            line_base_q <= line_base_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        issue_cnt_d    = issue_cnt_q;
        ret_cnt_d      = ret_cnt_q;
        line_base_d    = line_base_q;
        mem_read       = 1'b0;
        memory_address = '0;
        word_wr        = 1'b0;
        tag_wr         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.miss_detected) begin
                    line_base_d = bus.miss_address[ADDR_W-1:OFFSET_W];
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                // Issue side: one read per cycle until all words are requested.
                if (issue_cnt_q < CNT_W'(WORDS)) begin
                    mem_read       = 1'b1;
                    memory_address = {line_base_q, issue_cnt_q[WIDX_W-1:0], 1'b0};
                    issue_cnt_d    = issue_cnt_q + CNT_W'(1);
                end
                // Return side: memory answers in order, so the return count is the word index.
                if (bus.memory_data_valid && (ret_cnt_q < CNT_W'(WORDS))) begin
                    word_wr   = 1'b1;
                    ret_cnt_d = ret_cnt_q + CNT_W'(1);
                    if (ret_cnt_q == CNT_W'(WORDS - 1)) begin
                        tag_wr  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset aborts a fill in the same cycle: no strobe may escape while rst is high.
        if (rst) begin
            mem_read       = 1'b0;
            memory_address = '0;
            word_wr        = 1'b0;
            tag_wr         = 1'b0;
        end
    end

    onehot_decoder #(.N(WORDS)) u_word_dec (
        .index_i  (ret_cnt_q[WIDX_W-1:0]),
        .en_i     (word_wr),
        .onehot_o (bus.word_enable)
    );

    onehot_decoder #(.N(LINES)) u_block_dec (
        .index_i  (line_base_q[INDEX_W-1:0]),
        .en_i     (word_wr),
        .onehot_o (bus.block_enable)
    );

    assign bus.fsm_busy         = (state_q == FILL);
    assign bus.mem_read         = mem_read;
    assign bus.memory_address   = memory_address;
    assign bus.write_data_array = word_wr;
    assign bus.write_tag_array  = tag_wr;
    assign bus.data_out         = bus.memory_data;

endmodule
